mem_port_ctrl: RTL and testbench
================================

Name: mem_port_ctrl

Overview:
- Initiator side of the unified single-port instruction/data memory (inst_data_mem).
- Accepts instruction-fetch requests from the IF stage and load/store requests from the MEM stage, and arbitrates them onto the one memory port.
- Drives MemRead/MemWrite/func3/addr/data_in, registers the returned data, and flags misaligned or illegal accesses before they reach memory.

Parameters:
ADDR_W, 8, byte-address width of the memory port (256-byte memory)
DATA_W, 32, instruction/data word width; fixed at 32
CHECK_ALIGN, 1, 1 = reject misaligned accesses; 0 = pass all addresses through

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
fetch_req  input  1  IF stage requests instruction at fetch_pc
fetch_pc  input  ADDR_W  instruction byte address
fetch_ready  output  1  fetch request accepted this cycle when fetch_req && fetch_ready
fetch_valid  output  1  one-cycle pulse: fetch_inst / fetch_err valid
fetch_inst  output  DATA_W  registered instruction word
fetch_err  output  1  qualifies fetch_valid: misaligned pc, fetch_inst = 0
data_req  input  1  MEM stage load/store request
data_we  input  1  1 = store, 0 = load
data_func3  input  3  size/sign code: `F3_LSB=0, `F3_LSH=1, `F3_LSW=2, `F3_LSBU=4, `F3_LSHU=5
data_addr  input  ADDR_W  data byte address
data_wdata  input  DATA_W  store data
data_ready  output  1  data request accepted when data_req && data_ready
data_valid  output  1  one-cycle pulse: data_rdata / data_err valid
data_rdata  output  DATA_W  registered load result; 0 for stores and errors
data_err  output  1  qualifies data_valid: misaligned or illegal func3
MemRead  output  1  to memory
MemWrite  output  1  to memory; memory writes on falling clk
func3  output  3  to memory
addr  output  ADDR_W  to memory
data_in  output  DATA_W  to memory
data_out  input  DATA_W  combinational read data from memory

Behaviour:
- States: IDLE, ACCESS. Reset: state=IDLE. All outputs 0 except fetch_ready and data_ready, which follow their IDLE equations.
- data_ready = (state==IDLE). fetch_ready = (state==IDLE) && !data_req. Data has priority because it belongs to the older instruction.
- Acceptance at rising edge:
  - Latch the command (kind, we, func3, addr, wdata).
  - Legal request: go to ACCESS.
  - Illegal request: stay in IDLE and pulse valid+err in the next cycle. Error latency is 1 cycle.
- Legality (CHECK_ALIGN=1):
  - Fetch: illegal if pc[1:0]!=0.
  - LSH/LSHU: illegal if addr[0]!=0.
  - LSW: illegal if addr[1:0]!=0.
  - Alignment also keeps multi-byte accesses from wrapping past the memory ends.
- Legality, always checked:
  - Load with func3 in {3,6,7}: illegal.
  - Store with func3 not in {0,1,2}: illegal.
- ACCESS cycle drives the memory port from the latched command:
  - Fetch: MemRead=0, MemWrite=0, addr=pc.
  - Load: MemRead=1, MemWrite=0, func3, addr.
  - Store: MemRead=0, MemWrite=1, func3, addr, data_in=wdata. The write commits on the falling edge inside ACCESS.
- In IDLE, and after error acceptance, all memory-port outputs are 0.
- End of ACCESS (rising edge):
  - Fetch: capture data_out into fetch_inst.
  - Load: capture data_out into data_rdata.
  - Store: data_rdata=0.
  - Pulse the matching valid in the next cycle; return to IDLE.
- Latency: request accepted in cycle k; memory driven in k+1; valid in k+2. ready is high again in k+2, so peak throughput is one access per 2 cycles.
- Timing/hold rules:
  - valid outputs are exactly 1 cycle wide.
  - inst/rdata hold their value until the next response of the same kind.
  - err is 0 whenever its valid is 0.
- Requests arriving while state==ACCESS are not accepted; the requester must hold req.
- Simultaneous fetch_req && data_req in IDLE: data accepted, fetch stalls; fetch is accepted at the next IDLE cycle if data_req is low.
- Reset mid-ACCESS:
  - State returns to IDLE and no valid pulse is issued.
  - A store's falling-edge write in that cycle has already committed.
- Reset dominates acceptance in the same cycle.

Test Plan:
- Reset, then fetch_req pc=0x04, memory word 0x00A00093 at bytes 4..7 -> fetch_ready=1 in cycle k; addr=0x04 and MemRead=0 in k+1; fetch_valid=1 and fetch_inst=0x00A00093 in k+2.
- Store LSW addr=0x10 wdata=0xDEADBEEF, then load LSW addr=0x10 -> data_valid with data_rdata=0xDEADBEEF; then LSB addr=0x10 -> 0xFFFFFFEF; then LSBU addr=0x10 -> 0x000000EF.
- fetch_req and data_req (load) both high in IDLE -> data_ready=1 and fetch_ready=0; data_valid at k+2; fetch accepted at k+2 with fetch_valid at k+4.
- Misaligned accesses with CHECK_ALIGN=1:
  - LSW addr=0x13 -> next cycle data_valid=1, data_err=1, data_rdata=0; MemRead/MemWrite never asserted.
  - fetch pc=0x02 -> fetch_err=1.
- Store with func3=4 -> data_err=1 and no MemWrite. Load with func3=3 -> data_err=1.
- rst asserted during ACCESS of a load -> no data_valid; next cycle state IDLE, data_ready=1, all port outputs 0.

Source files
------------

// File: rtl/mem_port_ctrl_if.sv
// Purpose : bundles the IF/MEM request/response handshakes and the memory port of mem_port_ctrl.
// Latency : none; this is wiring only.
// Backpr. : requesters hold *_req until *_ready is seen high at a rising edge.
// Ports   : fetch_* (IF stage), data_* (MEM stage), MemRead/MemWrite/func3/addr/data_in/data_out (memory).
// Modports: slave = the controller, master = requesters and memory model.
interface mem_port_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_pc;
   logic              fetch_ready;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_inst;
   logic              fetch_err;

   logic              data_req;
   logic              data_we;
   logic [2:0]        data_func3;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_ready;
   logic              data_valid;
   logic [DATA_W-1:0] data_rdata;
   logic              data_err;

   logic              MemRead;
   logic              MemWrite;
   logic [2:0]        func3;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;

   modport slave (
      input  fetch_req, fetch_pc,
      output fetch_ready, fetch_valid, fetch_inst, fetch_err,
      input  data_req, data_we, data_func3, data_addr, data_wdata,
      output data_ready, data_valid, data_rdata, data_err,
      output MemRead, MemWrite, func3, addr, data_in,
      input  data_out
   );

   modport master (
      output fetch_req, fetch_pc,
      input  fetch_ready, fetch_valid, fetch_inst, fetch_err,
      output data_req, data_we, data_func3, data_addr, data_wdata,
      input  data_ready, data_valid, data_rdata, data_err,
      input  MemRead, MemWrite, func3, addr, data_in,
      output data_out
   );
endinterface

// File: rtl/mem_port_ctrl.sv
// Purpose : arbitrates IF fetches and MEM loads/stores onto the single inst/data memory port,
//           rejecting misaligned or illegal-func3 accesses before they reach memory.
// Latency : accept in k, memory driven in k+1, valid pulse in k+2; rejected requests pulse valid+err in k+1.
// Backpr. : ready is low during the access cycle; data beats fetch when both request in IDLE.
// Ports   : clk, rst (sync, active-high), bus (mem_port_ctrl_if.slave).
module mem_port_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter bit CHECK_ALIGN = 1'b1
) (
   input logic            clk,
   input logic            rst,
   mem_port_ctrl_if.slave bus
);
   localparam logic [2:0] F3_LSB  = 3'd0;
   localparam logic [2:0] F3_LSH  = 3'd1;
   localparam logic [2:0] F3_LSW  = 3'd2;
   localparam logic [2:0] F3_LSBU = 3'd4;
   localparam logic [2:0] F3_LSHU = 3'd5;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t state, state_nxt;

   // latched command driving the ACCESS cycle
   logic              cmd_fetch;
   logic              cmd_we;
   logic [2:0]        cmd_func3;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              fetch_valid_q, fetch_err_q;
   logic [DATA_W-1:0] fetch_inst_q;
   logic              data_valid_q, data_err_q;
   logic [DATA_W-1:0] data_rdata_q;

   logic              take_data, take_fetch;
   logic              data_bad, fetch_bad, f3_bad, size_bad;
   logic              fetch_ready_c, data_ready_c;
   logic              mem_read_c, mem_write_c;
   logic [2:0]        func3_c;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] data_in_c;

   // Legality of the incoming requests. Alignment also guarantees that a
   // multi-byte access never straddles the top of the byte address space.
   always_comb begin
      f3_bad   = 1'b0;
      size_bad = 1'b0;
      if (bus.data_we)
         f3_bad = !(bus.data_func3 inside {F3_LSB, F3_LSH, F3_LSW});
      else
         f3_bad = !(bus.data_func3 inside {F3_LSB, F3_LSH, F3_LSW, F3_LSBU, F3_LSHU});
      if (CHECK_ALIGN) begin
         case (bus.data_func3)
            F3_LSH, F3_LSHU: size_bad = bus.data_addr[0];
            F3_LSW:          size_bad = |bus.data_addr[1:0];
            default:         size_bad = 1'b0;
         endcase
      end
      data_bad  = f3_bad | size_bad;
      fetch_bad = CHECK_ALIGN && (|bus.fetch_pc[1:0]);
   end

   // FSM next state and all combinational outputs
   always_comb begin
      state_nxt     = state;
      take_data     = 1'b0;
      take_fetch    = 1'b0;
      data_ready_c  = 1'b0;
      fetch_ready_c = 1'b0;
      mem_read_c    = 1'b0;
      mem_write_c   = 1'b0;
      func3_c       = 3'd0;
      addr_c        = '0;
      data_in_c     = '0;
      case (state)
         IDLE: begin
            data_ready_c  = 1'b1;
            // data belongs to the older instruction, so it wins
            fetch_ready_c = !bus.data_req;
            take_data     = bus.data_req;
            take_fetch    = bus.fetch_req && !bus.data_req;
            if ((take_data && !data_bad) || (take_fetch && !fetch_bad))
               state_nxt = ACCESS;
         end
         ACCESS: begin
            state_nxt = IDLE;
            addr_c    = cmd_addr;
            // a fetch reads the word at addr with both strobes low
            if (!cmd_fetch) begin
               func3_c     = cmd_func3;
               mem_read_c  = !cmd_we;
               mem_write_c = cmd_we;
               if (cmd_we)
                  data_in_c = cmd_wdata;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_fetch     <= 1'b0;
         cmd_we        <= 1'b0;
         cmd_func3     <= 3'd0;
         cmd_addr      <= '0;
         cmd_wdata     <= '0;
         fetch_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
         fetch_inst_q  <= '0;
         data_valid_q  <= 1'b0;
         data_err_q    <= 1'b0;
         data_rdata_q  <= '0;
      end else begin
         fetch_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
         data_valid_q  <= 1'b0;
         data_err_q    <= 1'b0;
         if (take_data) begin
            cmd_fetch <= 1'b0;
            cmd_we    <= bus.data_we;
            cmd_func3 <= bus.data_func3;
            cmd_addr  <= bus.data_addr;
            cmd_wdata <= bus.data_wdata;
            if (data_bad) begin
               data_valid_q <= 1'b1;
               data_err_q   <= 1'b1;
               data_rdata_q <= '0;
            end
         end else if (take_fetch) begin
            cmd_fetch <= 1'b1;
            cmd_we    <= 1'b0;
            cmd_func3 <= 3'd0;
            cmd_addr  <= bus.fetch_pc;
            cmd_wdata <= '0;
            if (fetch_bad) begin
               fetch_valid_q <= 1'b1;
               fetch_err_q   <= 1'b1;
               fetch_inst_q  <= '0;
            end
         end
         if (state == ACCESS) begin
            if (cmd_fetch) begin
               fetch_valid_q <= 1'b1;
               fetch_inst_q  <= bus.data_out;
            end else begin
               data_valid_q <= 1'b1;
               data_rdata_q <= cmd_we ? '0 : bus.data_out;
            end
         end
      end
   end

   assign bus.fetch_ready = fetch_ready_c;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_inst  = fetch_inst_q;
   assign bus.fetch_err   = fetch_err_q;
   assign bus.data_ready  = data_ready_c;
   assign bus.data_valid  = data_valid_q;
   assign bus.data_rdata  = data_rdata_q;
   assign bus.data_err    = data_err_q;
   assign bus.MemRead     = mem_read_c;
   assign bus.MemWrite    = mem_write_c;
   assign bus.func3       = func3_c;
   assign bus.addr        = addr_c;
   assign bus.data_in     = data_in_c;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Purpose : bench for mem_port_ctrl with a byte-array memory and a transaction-level reference model.
// Latency : model schedules access at k+1 and response at k+2 (k+1 for rejected requests).
// Backpr. : the stimulus holds each request until it is seen accepted.
module tb_mem_port_ctrl;
   localparam int AW = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CHECK_ALIGN(1'b1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] env_mem [256];
   logic [7:0] ref_mem [256];

   // ---------------- memory environment ----------------
   always_comb begin
      logic [7:0]  a0, a1, a2, a3;
      logic [31:0] w, d;
      a0 = bus.addr;
      a1 = a0 + 8'd1;
      a2 = a0 + 8'd2;
      a3 = a0 + 8'd3;
      w  = {env_mem[a3], env_mem[a2], env_mem[a1], env_mem[a0]};
      d  = w;
      if (bus.MemRead) begin
         case (bus.func3)
            3'd0:    d = {{24{w[7]}}, w[7:0]};
            3'd1:    d = {{16{w[15]}}, w[15:0]};
            3'd2:    d = w;
            3'd4:    d = {24'd0, w[7:0]};
            3'd5:    d = {16'd0, w[15:0]};
            default: d = 32'd0;
         endcase
      end
      bus.data_out = d;
   end

   always @(negedge clk) begin
      if (bus.MemWrite) begin
         case (bus.func3)
            3'd0: env_mem[bus.addr] = bus.data_in[7:0];
            3'd1: begin
               env_mem[bus.addr]        = bus.data_in[7:0];
               env_mem[bus.addr + 8'd1] = bus.data_in[15:8];
            end
            3'd2: begin
               env_mem[bus.addr]        = bus.data_in[7:0];
               env_mem[bus.addr + 8'd1] = bus.data_in[15:8];
               env_mem[bus.addr + 8'd2] = bus.data_in[23:16];
               env_mem[bus.addr + 8'd3] = bus.data_in[31:24];
            end
            default: ;
         endcase
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chkb(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int acc_size(input int f3);
      return (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
   endfunction

   function automatic logic [31:0] ref_load(input int f3, input int a);
      longint v;
      int     n;
      n = acc_size(f3);
      v = 0;
      for (int i = n - 1; i >= 0; i--)
         v = v * 256 + longint'(ref_mem[(a + i) % 256]);
      if (f3 < 4 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   function automatic bit ref_illegal(input bit is_fetch, input bit we, input int f3, input int a);
      if (is_fetch) return (a % 4) != 0;
      if (we && !(f3 inside {0, 1, 2})) return 1'b1;
      if (!we && (f3 inside {3, 6, 7})) return 1'b1;
      return (a % acc_size(f3)) != 0;
   endfunction

   int          cyc = 0;
   int          acc_cyc = -1;
   bit          acc_fetch, acc_we;
   int          acc_f3, acc_a;
   logic [31:0] acc_wd;
   int          resp_cyc = -1;
   bit          resp_fetch, resp_err;
   logic [31:0] resp_val;
   logic [31:0] hold_inst = 32'd0;
   logic [31:0] hold_rdata = 32'd0;

   always @(negedge clk) begin
      bit          in_acc, rv;
      logic [31:0] e_addr, e_din;
      logic [2:0]  e_f3;
      in_acc = (acc_cyc == cyc);
      rv     = (resp_cyc == cyc);
      if (rv) begin
         if (resp_fetch) hold_inst = resp_val;
         else            hold_rdata = resp_val;
      end
      e_addr = in_acc ? 32'(acc_a) : 32'd0;
      e_f3   = (in_acc && !acc_fetch) ? 3'(acc_f3) : 3'd0;
      e_din  = (in_acc && !acc_fetch && acc_we) ? acc_wd : 32'd0;

      chkb("data_ready",  bus.data_ready,  !in_acc);
      chkb("fetch_ready", bus.fetch_ready, !in_acc && !bus.data_req);
      chkb("MemRead",     bus.MemRead,     in_acc && !acc_fetch && !acc_we);
      chkb("MemWrite",    bus.MemWrite,    in_acc && !acc_fetch && acc_we);
      chk ("func3",       32'(bus.func3),  32'(e_f3));
      chk ("addr",        32'(bus.addr),   e_addr);
      chk ("data_in",     bus.data_in,     e_din);
      chkb("fetch_valid", bus.fetch_valid, rv && resp_fetch);
      chkb("fetch_err",   bus.fetch_err,   rv && resp_fetch && resp_err);
      chk ("fetch_inst",  bus.fetch_inst,  hold_inst);
      chkb("data_valid",  bus.data_valid,  rv && !resp_fetch);
      chkb("data_err",    bus.data_err,    rv && !resp_fetch && resp_err);
      chk ("data_rdata",  bus.data_rdata,  hold_rdata);

      // advance the model to the next cycle
      if (in_acc && !acc_fetch && acc_we)
         for (int i = 0; i < acc_size(acc_f3); i++)
            ref_mem[(acc_a + i) % 256] = 8'((acc_wd >> (8 * i)) & 32'hFF);
      if (rst) begin
         acc_cyc    = -1;
         resp_cyc   = -1;
         hold_inst  = 32'd0;
         hold_rdata = 32'd0;
      end else if (in_acc) begin
         resp_cyc   = cyc + 1;
         resp_fetch = acc_fetch;
         resp_err   = 1'b0;
         if (acc_fetch)   resp_val = ref_load(2, acc_a);
         else if (acc_we) resp_val = 32'd0;
         else             resp_val = ref_load(acc_f3, acc_a);
      end else if (bus.data_req || bus.fetch_req) begin
         acc_fetch = !bus.data_req;
         acc_we    = bus.data_req ? bus.data_we : 1'b0;
         acc_f3    = bus.data_req ? int'(bus.data_func3) : 0;
         acc_a     = bus.data_req ? int'(bus.data_addr) : int'(bus.fetch_pc);
         acc_wd    = bus.data_wdata;
         if (ref_illegal(acc_fetch, acc_we, acc_f3, acc_a)) begin
            resp_cyc   = cyc + 1;
            resp_fetch = acc_fetch;
            resp_err   = 1'b1;
            resp_val   = 32'd0;
         end else begin
            acc_cyc = cyc + 1;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_data(input bit we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output bit er,
                          output int lat);
      bit acc = 1'b0;
      bit got = 1'b0;
      int n = 0;
      bus.data_req   = 1'b1;
      bus.data_we    = we;
      bus.data_func3 = f3;
      bus.data_addr  = a;
      bus.data_wdata = wd;
      rd  = 32'd0;
      er  = 1'b0;
      lat = 1;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = bus.data_ready;
         tick();
         n++;
      end
      bus.data_req = 1'b0;
      while (acc && !got && lat < 20) begin
         @(negedge clk);
         if (bus.data_valid) begin
            got = 1'b1;
            rd  = bus.data_rdata;
            er  = bus.data_err;
         end else begin
            tick();
            lat++;
         end
      end
      chkb("data_response_seen", got, 1'b1);
      tick();
   endtask

   task automatic do_fetch(input logic [7:0] pc, output logic [31:0] inst, output bit er,
                           output int lat);
      bit acc = 1'b0;
      bit got = 1'b0;
      int n = 0;
      bus.fetch_req = 1'b1;
      bus.fetch_pc  = pc;
      inst = 32'd0;
      er   = 1'b0;
      lat  = 1;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = bus.fetch_ready;
         tick();
         n++;
      end
      bus.fetch_req = 1'b0;
      while (acc && !got && lat < 20) begin
         @(negedge clk);
         if (bus.fetch_valid) begin
            got  = 1'b1;
            inst = bus.fetch_inst;
            er   = bus.fetch_err;
         end else begin
            tick();
            lat++;
         end
      end
      chkb("fetch_response_seen", got, 1'b1);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      bit          er;
      int          lat;
      bit          dhs, fhs;

      for (int i = 0; i < 256; i++) begin
         env_mem[i] = 8'($urandom);
         ref_mem[i] = env_mem[i];
      end
      env_mem[4] = 8'h93; env_mem[5] = 8'h00; env_mem[6] = 8'hA0; env_mem[7] = 8'h00;
      for (int i = 4; i < 8; i++) ref_mem[i] = env_mem[i];

      bus.fetch_req = 1'b0; bus.fetch_pc = '0;
      bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_func3 = 3'd0;
      bus.data_addr = '0; bus.data_wdata = '0;

      repeat (3) tick();
      @(negedge clk);
      chkb("reset_fetch_ready", bus.fetch_ready, 1'b1);
      chkb("reset_data_ready",  bus.data_ready,  1'b1);
      chkb("reset_data_valid",  bus.data_valid,  1'b0);
      chkb("reset_MemRead",     bus.MemRead,     1'b0);
      chk ("reset_fetch_inst",  bus.fetch_inst,  32'd0);
      tick();
      rst = 1'b0;

      // fetch at pc 4: ready in k, addr driven in k+1, instruction in k+2
      bus.fetch_req = 1'b1; bus.fetch_pc = 8'h04;
      @(negedge clk); chkb("t1_fetch_ready", bus.fetch_ready, 1'b1);
      tick(); bus.fetch_req = 1'b0;
      @(negedge clk); chk("t1_addr", 32'(bus.addr), 32'h04); chkb("t1_MemRead", bus.MemRead, 1'b0);
      tick();
      @(negedge clk); chkb("t1_fetch_valid", bus.fetch_valid, 1'b1);
      chk("t1_fetch_inst", bus.fetch_inst, 32'h00A00093);
      tick();

      // store then loads of different sizes
      do_data(1'b1, 3'd2, 8'h10, 32'hDEADBEEF, rd, er, lat);
      chk("t2_store_rdata", rd, 32'd0); chk("t2_store_lat", 32'(lat), 32'd2);
      do_data(1'b0, 3'd2, 8'h10, 32'd0, rd, er, lat);
      chk("t2_lsw", rd, 32'hDEADBEEF);
      do_data(1'b0, 3'd0, 8'h10, 32'd0, rd, er, lat);
      chk("t2_lsb", rd, 32'hFFFFFFEF);
      do_data(1'b0, 3'd4, 8'h10, 32'd0, rd, er, lat);
      chk("t2_lsbu", rd, 32'h000000EF);

      // simultaneous requests: data first, fetch at k+2, fetch valid at k+4
      bus.fetch_req = 1'b1; bus.fetch_pc = 8'h04;
      bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_func3 = 3'd2; bus.data_addr = 8'h10;
      @(negedge clk); chkb("t3_data_ready", bus.data_ready, 1'b1);
      chkb("t3_fetch_ready", bus.fetch_ready, 1'b0);
      tick(); bus.data_req = 1'b0;
      tick();
      @(negedge clk); chkb("t3_data_valid", bus.data_valid, 1'b1);
      chk("t3_rdata", bus.data_rdata, 32'hDEADBEEF);
      chkb("t3_fetch_ready_k2", bus.fetch_ready, 1'b1);
      tick(); bus.fetch_req = 1'b0;
      @(negedge clk); chkb("t3_fetch_valid_k3", bus.fetch_valid, 1'b0);
      tick();
      @(negedge clk); chkb("t3_fetch_valid_k4", bus.fetch_valid, 1'b1);
      chk("t3_fetch_inst", bus.fetch_inst, 32'h00A00093);
      tick();

      // rejected requests
      do_data(1'b0, 3'd2, 8'h13, 32'd0, rd, er, lat);
      chkb("t4_lsw_mis_err", er, 1'b1); chk("t4_lsw_mis_rdata", rd, 32'd0);
      chk("t4_lsw_mis_lat", 32'(lat), 32'd1);
      do_fetch(8'h02, rd, er, lat);
      chkb("t4_fetch_mis_err", er, 1'b1); chk("t4_fetch_mis_inst", rd, 32'd0);
      do_data(1'b1, 3'd4, 8'h20, 32'h12345678, rd, er, lat);
      chkb("t5_store_f3_4_err", er, 1'b1);
      do_data(1'b0, 3'd3, 8'h20, 32'd0, rd, er, lat);
      chkb("t5_load_f3_3_err", er, 1'b1);

      // reset during the access cycle of a load
      bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_func3 = 3'd2; bus.data_addr = 8'h14;
      @(negedge clk); chkb("t6_data_ready", bus.data_ready, 1'b1);
      tick(); bus.data_req = 1'b0; rst = 1'b1;
      @(negedge clk); chkb("t6_MemRead_access", bus.MemRead, 1'b1);
      tick(); rst = 1'b0;
      @(negedge clk); chkb("t6_no_valid", bus.data_valid, 1'b0);
      chkb("t6_data_ready_after", bus.data_ready, 1'b1);
      chkb("t6_MemRead_after", bus.MemRead, 1'b0);
      chk("t6_addr_after", 32'(bus.addr), 32'd0);
      tick();
      @(negedge clk); chkb("t6_no_valid_later", bus.data_valid, 1'b0);
      tick();

      // randomized traffic, requests held until accepted
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         dhs = bus.data_req && bus.data_ready;
         fhs = bus.fetch_req && bus.fetch_ready;
         tick();
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 249) == 0) rst = 1'b1;
         if (!bus.data_req || dhs) begin
            bus.data_req = ($urandom_range(0, 2) == 0);
            if (bus.data_req) begin
               int f3, a;
               f3 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7))
                                                : int'($urandom_range(0, 4));
               if (f3 == 3) f3 = 5;
               a = int'($urandom_range(0, 255));
               if ($urandom_range(0, 3) != 0) a = a - (a % acc_size(f3));
               bus.data_we    = 1'($urandom_range(0, 1));
               bus.data_func3 = 3'(f3);
               bus.data_addr  = 8'(a);
               bus.data_wdata = $urandom;
            end
         end
         if (!bus.fetch_req || fhs) begin
            bus.fetch_req = ($urandom_range(0, 1) == 0);
            if (bus.fetch_req)
               bus.fetch_pc = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                          : 8'($urandom_range(0, 63) * 4);
         end
      end
      bus.data_req  = 1'b0;
      bus.fetch_req = 1'b0;
      rst = 1'b0;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
